mem_responder: RTL and testbench

- Word-granular backing-memory responder for the cache's external memory interface.
- Accepts read and write requests from a cache (the initiator) through a ready/valid handshake.
- Returns read data in order after a fixed, parameterised latency; throttles the initiator with ready after writes and when the outstanding-read limit is reached.
- Used as the memory behind the instruction and data caches in system integration and in cache benches.

---
 rtl/mem_if_pkg.sv | 32 +++
 rtl/resp_delay_line.sv | 49 ++++
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the cache <-> backing-memory interface: bus widths,
// the byte-to-word address shift, and a request decoder used by initiators
// and responders alike.
// ---------------------------------------------------------------------------
package mem_if_pkg;

  localparam int MEM_DATA_W     = 32;
  localparam int MEM_ADDR_W     = 32;
  localparam int MEM_BYTE_SHIFT = 2;   // byte address -> word index

  typedef logic [MEM_DATA_W-1:0] mem_data_t;
  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_READ,
    REQ_WRITE,
    REQ_BAD     // read and write asserted together
  } mem_req_e;

  function automatic mem_req_e decode_req(input logic ren, input logic wen);
    case ({ren, wen})
      2'b10:   return REQ_READ;
      2'b01:   return REQ_WRITE;
      2'b11:   return REQ_BAD;
      default: return REQ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/resp_delay_line.sv
// ---------------------------------------------------------------------------
// resp_delay_line
// LATENCY-stage shift register of {valid, data}. A beat loaded on edge N
// appears at the output from edge N+LATENCY-1. Asynchronous active-low clear
// empties every stage, so in-flight beats are dropped.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low clear
//   in_valid  beat entering stage 0
//   in_data   data entering stage 0
//   out_valid valid of the last stage
//   out_data  data of the last stage
// ---------------------------------------------------------------------------
module resp_delay_line #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0]             valid_q;
  logic [LATENCY-1:0][DATA_W-1:0] data_q;

  // NOTE: non-blocking assignments let every stage sample its predecessor's
  // old value, so the loop order does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
// Word-granular backing memory for a cache. Accepts one read or write per
// cycle through a registered ready, returns reads in order after LATENCY
// cycles, limits outstanding reads to MAX_OUT and holds ready low for
// WR_STALL cycles after each write. Illegal requests (read+write together,
// address beyond the array) set a sticky error flag.
//
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   o_mem_ready  request accepted on the next rising edge when high
//   i_mem_addr   byte address, word index in [ADDR_W+1:2]
//   i_mem_ren    read request
//   i_mem_wen    write request
//   i_mem_wdata  write data (full word)
//   o_mem_rdata  read data, valid with o_mem_valid
//   o_mem_valid  one-cycle pulse per read response
//   o_err        sticky protocol/range error, cleared only by reset
// ---------------------------------------------------------------------------
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int LATENCY  = 4,
  parameter int MAX_OUT  = 4,
  parameter int WR_STALL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_mem_ready,
  input  logic [MEM_ADDR_W-1:0] i_mem_addr,
  input  logic                  i_mem_ren,
  input  logic                  i_mem_wen,
  input  logic [MEM_DATA_W-1:0] i_mem_wdata,
  output logic [MEM_DATA_W-1:0] o_mem_rdata,
  output logic                  o_mem_valid,
  output logic                  o_err
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int STALL_W = (WR_STALL > 0) ? $clog2(WR_STALL + 1) : 1;

  localparam logic [OUT_W-1:0]   OUT_MAX   = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0]   OUT_ONE   = OUT_W'(1);
  localparam logic [STALL_W-1:0] STALL_SET = STALL_W'(WR_STALL);
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  mem_data_t mem [DEPTH];

  logic               ready_q;
  logic [OUT_W-1:0]   outstanding_q;
  logic [STALL_W-1:0] stall_q;
  logic               err_q;

  logic [ADDR_W-1:0]  idx;
  logic               out_of_range;
  mem_req_e           req;
  logic               rd_acc;
  logic               wr_do;
  logic               bad_req;
  mem_data_t          rd_data;
  logic               resp_done;

  logic [OUT_W-1:0]   outstanding_next;
  logic [STALL_W-1:0] stall_next;
  logic               ready_next;

  // Byte-offset bits carry no information for a word-only memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_mem_addr[MEM_BYTE_SHIFT-1:0];

  assign idx          = i_mem_addr[ADDR_W+MEM_BYTE_SHIFT-1:MEM_BYTE_SHIFT];
  assign out_of_range = (i_mem_addr >> (ADDR_W + MEM_BYTE_SHIFT)) != '0;
  assign req          = decode_req(i_mem_ren, i_mem_wen);

  // Out-of-range reads still respond (with zero) so the initiator never hangs;
  // out-of-range writes are discarded.
  assign rd_acc  = ready_q && (req == REQ_READ);
  assign wr_do   = ready_q && (req == REQ_WRITE) && !out_of_range;
  assign bad_req = ready_q && ((req == REQ_BAD) ||
                               ((req != REQ_NONE) && out_of_range));
  assign rd_data = out_of_range ? '0 : mem[idx];

  // A response leaves the pipeline on the edge that ends its valid pulse.
  assign resp_done = o_mem_valid;

  // NOTE: every variable gets a default before the case, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    outstanding_next = outstanding_q;
    case ({rd_acc, resp_done})
      2'b10:   outstanding_next = outstanding_q + OUT_ONE;
      2'b01:   outstanding_next = outstanding_q - OUT_ONE;
      default: outstanding_next = outstanding_q;
    endcase

    stall_next = '0;
    if (wr_do)               stall_next = STALL_SET;
    else if (stall_q != '0)  stall_next = stall_q - STALL_ONE;

    // Ready is computed from next-state counters and registered, so it
    // never depends combinationally on the request inputs.
    ready_next = (outstanding_next < OUT_MAX) && (stall_next == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q       <= 1'b0;
      outstanding_q <= '0;
      stall_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      ready_q       <= ready_next;
      outstanding_q <= outstanding_next;
      stall_q       <= stall_next;
      err_q         <= err_q | bad_req;
    end
  end

  // NOTE: the storage array has no reset; contents survive i_rst_n and a
  // reset port would prevent mapping it onto RAM.
  always_ff @(posedge i_clk) begin
    if (wr_do) mem[idx] <= i_mem_wdata;
  end

  resp_delay_line #(
    .LATENCY (LATENCY),
    .DATA_W  (MEM_DATA_W)
  ) u_delay (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .in_valid  (rd_acc),
    .in_data   (rd_acc ? rd_data : '0),
    .out_valid (o_mem_valid),
    .out_data  (o_mem_rdata)
  );

  assign o_mem_ready = ready_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Three instances with different
// parameter sets share clock and reset:
//   0: LATENCY=4 MAX_OUT=4 WR_STALL=1
//   1: LATENCY=4 MAX_OUT=2 WR_STALL=2
//   2: LATENCY=1 MAX_OUT=1 WR_STALL=0
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_mem_responder;

  localparam int N = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  logic        ren   [N];
  logic        wen   [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic        ready [N];
  logic        valid [N];
  logic        err   [N];
  logic [31:0] rdata [N];

  int vcount [N] = '{default: 0};
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(12), .LATENCY(4), .MAX_OUT(4), .WR_STALL(1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_ready(ready[0]), .i_mem_addr(addr[0]),
    .i_mem_ren(ren[0]), .i_mem_wen(wen[0]), .i_mem_wdata(wdata[0]),
    .o_mem_rdata(rdata[0]), .o_mem_valid(valid[0]), .o_err(err[0]));

  mem_responder #(.ADDR_W(12), .LATENCY(4), .MAX_OUT(2), .WR_STALL(2)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_ready(ready[1]), .i_mem_addr(addr[1]),
    .i_mem_ren(ren[1]), .i_mem_wen(wen[1]), .i_mem_wdata(wdata[1]),
    .o_mem_rdata(rdata[1]), .o_mem_valid(valid[1]), .o_err(err[1]));

  mem_responder #(.ADDR_W(12), .LATENCY(1), .MAX_OUT(1), .WR_STALL(0)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .o_mem_ready(ready[2]), .i_mem_addr(addr[2]),
    .i_mem_ren(ren[2]), .i_mem_wen(wen[2]), .i_mem_wdata(wdata[2]),
    .o_mem_rdata(rdata[2]), .o_mem_valid(valid[2]), .o_err(err[2]));

  // Count valid cycles away from the rising edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (valid[i] === 1'b1) vcount[i]++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (ready[idx] !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    if (n >= 20) check("ready_timeout", {31'd0, ready[idx]}, 32'd1);
  endtask

  // Present a request, hold it until the accepting edge, then go idle.
  task automatic issue(input int idx, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    ren[idx] = r; wen[idx] = w; addr[idx] = a; wdata[idx] = d;
    wait_ready(idx);
    cyc();
    ren[idx] = 1'b0; wen[idx] = 1'b0;
  endtask

  // Called just after the accepting edge: the response must appear after
  // exactly lat further edges with the expected data.
  task automatic wait_resp(input int idx, input int lat, input logic [31:0] exp,
                           input string tag);
    int n = 0;
    while (valid[idx] !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_data"}, rdata[idx], exp);
  endtask

  initial begin
    int v0, acc, rsp, maxo;
    for (int i = 0; i < N; i++) begin
      ren[i] = 1'b0; wen[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready",  {31'd0, ready[0]}, 32'd0);
    check("rst_valid",  {31'd0, valid[0]}, 32'd0);
    check("rst_rdata",  rdata[0], 32'd0);
    check("rst_err",    {31'd0, err[0]}, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    check("rel_ready_before_edge", {31'd0, ready[0]}, 32'd0);
    cyc();
    check("rel_ready0", {31'd0, ready[0]}, 32'd1);
    check("rel_ready2", {31'd0, ready[2]}, 32'd1);

    // 1: write then read with LATENCY=4, one-cycle write stall
    issue(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    check("t1_stall_lo", {31'd0, ready[0]}, 32'd0);
    cyc();
    check("t1_stall_hi", {31'd0, ready[0]}, 32'd1);
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_resp(0, 3, 32'hDEADBEEF, "t1_rd");
    cyc();
    check("t1_pulse_end", {31'd0, valid[0]}, 32'd0);

    // 2: four back-to-back reads fill MAX_OUT=4
    for (int k = 0; k < 4; k++) issue(0, 1'b0, 1'b1, 32'(k * 4), 32'(k + 1));
    ren[0] = 1'b1; addr[0] = 32'h0;
    wait_ready(0);
    for (int k = 0; k < 4; k++) begin
      addr[0] = 32'(k * 4);
      check($sformatf("t2_rdy%0d", k), {31'd0, ready[0]}, 32'd1);
      cyc();
    end
    ren[0] = 1'b0;
    check("t2_full_lo", {31'd0, ready[0]}, 32'd0);
    check("t2_v1", {31'd0, valid[0]}, 32'd1);
    check("t2_d1", rdata[0], 32'd1);
    cyc();
    check("t2_rdy_back", {31'd0, ready[0]}, 32'd1);
    check("t2_d2", rdata[0], 32'd2);
    cyc();
    check("t2_d3", rdata[0], 32'd3);
    cyc();
    check("t2_v4", {31'd0, valid[0]}, 32'd1);
    check("t2_d4", rdata[0], 32'd4);
    cyc();
    check("t2_end", {31'd0, valid[0]}, 32'd0);

    // 5: illegal read+write, out-of-range write and read
    wait_ready(0);
    check("t5_err_clear", {31'd0, err[0]}, 32'd0);
    ren[0] = 1'b1; wen[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678;
    cyc();
    ren[0] = 1'b0; wen[0] = 1'b0;
    check("t5_err_set", {31'd0, err[0]}, 32'd1);
    check("t5_no_stall", {31'd0, ready[0]}, 32'd1);
    v0 = vcount[0];
    repeat (6) cyc();
    check("t5_no_pulse", vcount[0] - v0, 32'd0);
    issue(0, 1'b0, 1'b1, 32'h8000_0040, 32'hBAD0BAD0);
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_resp(0, 3, 32'hDEADBEEF, "t5_mem_kept");
    issue(0, 1'b1, 1'b0, 32'h8000_0044, 32'h0);
    wait_resp(0, 3, 32'h0, "t5_oor_rd");
    check("t5_err_sticky", {31'd0, err[0]}, 32'd1);

    // 4: WR_STALL=2, read held during the stall returns new data
    issue(1, 1'b0, 1'b1, 32'h10, 32'hCAFE0010);
    ren[1] = 1'b1; addr[1] = 32'h10;
    check("t4_lo1", {31'd0, ready[1]}, 32'd0);
    cyc();
    check("t4_lo2", {31'd0, ready[1]}, 32'd0);
    cyc();
    check("t4_hi", {31'd0, ready[1]}, 32'd1);
    cyc();
    ren[1] = 1'b0;
    wait_resp(1, 3, 32'hCAFE0010, "t4_rd");

    // 3: MAX_OUT=2 under continuous read pressure
    repeat (6) cyc();
    acc = 0; rsp = 0; maxo = 0;
    for (int c = 0; c < 40; c++) begin
      ren[1] = 1'b1; addr[1] = 32'(c * 4);
      if (ready[1] === 1'b1) acc++;
      cyc();
      if (valid[1] === 1'b1) rsp++;
      if (acc - rsp > maxo) maxo = acc - rsp;
    end
    ren[1] = 1'b0;
    repeat (10) begin
      cyc();
      if (valid[1] === 1'b1) rsp++;
    end
    check("t3_max_out", maxo, 32'd2);
    check("t3_rsp_eq_acc", rsp, acc);
    check("t3_progress", {31'd0, acc >= 10}, 32'd1);

    // LATENCY=1, MAX_OUT=1, no write stall
    issue(2, 1'b0, 1'b1, 32'h20, 32'h00000A5A);
    check("t7_no_stall", {31'd0, ready[2]}, 32'd1);
    issue(2, 1'b1, 1'b0, 32'h20, 32'h0);
    check("t7_full_lo", {31'd0, ready[2]}, 32'd0);
    wait_resp(2, 0, 32'h00000A5A, "t7_rd");
    cyc();
    check("t7_end", {31'd0, valid[2]}, 32'd0);
    check("t7_rdy_back", {31'd0, ready[2]}, 32'd1);

    // 6: asynchronous reset with reads in flight
    wait_ready(0);
    for (int k = 0; k < 3; k++) begin
      ren[0] = 1'b1; addr[0] = 32'(k * 4);
      cyc();
    end
    ren[0] = 1'b0;
    cyc();
    check("t6_pre_v", {31'd0, valid[0]}, 32'd1);
    check("t6_pre_d", rdata[0], 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", {31'd0, valid[0]}, 32'd0);
    check("t6_async_rdata", rdata[0], 32'd0);
    check("t6_async_ready", {31'd0, ready[0]}, 32'd0);
    check("t6_async_err",   {31'd0, err[0]}, 32'd0);
    v0 = vcount[0];
    cyc(); cyc();
    rst_n = 1'b1;
    repeat (8) cyc();
    check("t6_no_pulses", vcount[0] - v0, 32'd0);
    check("t6_ready", {31'd0, ready[0]}, 32'd1);
    issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_resp(0, 3, 32'hDEADBEEF, "t6_mem_kept");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
